// File: rtl/riscv_ctrl_defs.sv
// Control encodings shared by the branch resolution logic: PC-source kinds, branch funct3
// codes, PC-select values and compare-flag bit positions.
package riscv_ctrl_defs;

  localparam logic [1:0] PCS_NONE = 2'b00;
  localparam logic [1:0] PCS_BR   = 2'b01;
  localparam logic [1:0] PCS_JAL  = 2'b10;
  localparam logic [1:0] PCS_JALR = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_PCIMM  = 2'b01;
  localparam logic [1:0] PCSRC_RS1IMM = 2'b10;

  localparam int unsigned FLAG_EQ  = 2;
  localparam int unsigned FLAG_LT  = 1;
  localparam int unsigned FLAG_LTU = 0;

  // 010/011 are the only holes in the branch funct3 space.
  function automatic logic br_legal(input logic [2:0] funct3);
    return funct3[2:1] != 2'b01;
  endfunction

  function automatic logic br_taken(input logic [2:0] funct3, input logic [2:0] flags);
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = flags[FLAG_EQ];
      F3_BNE:  taken = ~flags[FLAG_EQ];
      F3_BLT:  taken = flags[FLAG_LT];
      F3_BGE:  taken = ~flags[FLAG_LT];
      F3_BLTU: taken = flags[FLAG_LTU];
      F3_BGEU: taken = ~flags[FLAG_LTU];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_unit_bht_if.sv
// Execute/Fetch-side signal bundle of the branch unit; master drives resolution and lookup
// inputs, slave is the branch unit itself.
interface branch_unit_bht_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned STAT_WIDTH = 16
);

  logic [1:0]            PCS;
  logic [2:0]            Funct3;
  logic [2:0]            ALUFlags;
  logic                  ResolveValid;
  logic [PC_WIDTH-1:0]   PCE;
  logic                  PredTakenE;
  logic [PC_WIDTH-1:0]   PCF;
  logic                  PredTakenF;
  logic [1:0]            PCSrc;
  logic                  Mispredict;
  logic                  StatClear;
  logic [STAT_WIDTH-1:0] BranchCount;
  logic [STAT_WIDTH-1:0] MispredictCount;

  modport master (
    output PCS, Funct3, ALUFlags, ResolveValid, PCE, PredTakenE, PCF, StatClear,
    input  PredTakenF, PCSrc, Mispredict, BranchCount, MispredictCount
  );

  modport slave (
    input  PCS, Funct3, ALUFlags, ResolveValid, PCE, PredTakenE, PCF, StatClear,
    output PredTakenF, PCSrc, Mispredict, BranchCount, MispredictCount
  );

endinterface

// File: rtl/branch_unit_bht_table.sv
// Array of saturating up/down counters with one combinational read port and one
// increment/decrement write port; every entry resets to weakly-not-taken.
module bht_sat_table #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned CNT_WIDTH = 2,
  localparam int unsigned IdxW     = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IdxW-1:0]      rd_idx_i,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  input  logic                 wr_en_i,
  input  logic [IdxW-1:0]      wr_idx_i,
  input  logic                 wr_inc_i
);

  localparam logic [CNT_WIDTH-1:0] CntRst = CNT_WIDTH'((2 ** (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [CNT_WIDTH-1:0] cnt_q [DEPTH];
  logic [CNT_WIDTH-1:0] cnt_cur;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Reads see the registered array, so a same-cycle write is visible only next cycle.
  assign rd_cnt_o = cnt_q[rd_idx_i];
  assign cnt_cur  = cnt_q[wr_idx_i];

  always_comb begin
    cnt_d = cnt_cur;
    if (wr_inc_i) begin
      if (cnt_cur != CntMax) cnt_d = cnt_cur + CNT_WIDTH'(1);
    end else begin
      if (cnt_cur != '0) cnt_d = cnt_cur - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CntRst;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_unit_bht.sv
// Branch/jump resolution with PC-source select, BHT-based Fetch prediction, misprediction
// flag and saturating branch/mispredict statistics.
module branch_unit_bht
  import riscv_ctrl_defs::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic              CLK,
  input  logic              RESETn,
  branch_unit_bht_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);

  logic [IdxW-1:0]       idx_f;
  logic [IdxW-1:0]       idx_e;
  logic [CNT_WIDTH-1:0]  pred_cnt;
  logic                  taken;
  logic                  upd;
  logic                  mispredict;
  logic [1:0]            pcsrc;
  logic [STAT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;
  logic                  unused_pc_bits;

  // No tags: PCs that differ only above the index bits deliberately alias.
  assign idx_f          = bus.PCF[IdxW+1:2];
  assign idx_e          = bus.PCE[IdxW+1:2];
  assign unused_pc_bits = ^{bus.PCF, bus.PCE};

  bht_sat_table #(
    .DEPTH     (BHT_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_table (
    .clk_i    (CLK),
    .rst_ni   (RESETn),
    .rd_idx_i (idx_f),
    .rd_cnt_o (pred_cnt),
    .wr_en_i  (upd),
    .wr_idx_i (idx_e),
    .wr_inc_i (taken)
  );

  assign bus.PredTakenF = pred_cnt[CNT_WIDTH-1];

  always_comb begin
    taken      = br_taken(bus.Funct3, bus.ALUFlags);
    upd        = RESETn && bus.ResolveValid && (bus.PCS == PCS_BR) && br_legal(bus.Funct3);
    mispredict = upd && (taken != bus.PredTakenE);
    pcsrc      = PCSRC_PC4;
    if (RESETn && bus.ResolveValid) begin
      unique case (bus.PCS)
        PCS_NONE: pcsrc = PCSRC_PC4;
        PCS_BR:   pcsrc = taken ? PCSRC_PCIMM : PCSRC_PC4;
        PCS_JAL:  pcsrc = PCSRC_PCIMM;
        PCS_JALR: pcsrc = PCSRC_RS1IMM;
        default:  pcsrc = PCSRC_PC4;
      endcase
    end
  end

  assign bus.PCSrc      = pcsrc;
  assign bus.Mispredict = mispredict;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (bus.StatClear) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else begin
      if (upd && (br_cnt_q != '1))         br_cnt_d  = br_cnt_q + STAT_WIDTH'(1);
      if (mispredict && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign bus.BranchCount     = br_cnt_q;
  assign bus.MispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Randomised and directed bench for branch_unit_bht against a counter-array reference model.
module tb_branch_unit_bht;

  localparam int PC_WIDTH   = 32;
  localparam int BHT_DEPTH  = 64;
  localparam int CNT_WIDTH  = 2;
  localparam int STAT_WIDTH = 4;
  localparam int STAT_MAX   = 15;

  logic CLK;
  logic RESETn;

  branch_unit_bht_if #(.PC_WIDTH(PC_WIDTH), .STAT_WIDTH(STAT_WIDTH)) bus ();

  branch_unit_bht #(
    .PC_WIDTH   (PC_WIDTH),
    .BHT_DEPTH  (BHT_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .STAT_WIDTH (STAT_WIDTH)
  ) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: counter value per entry (0..3) and the two statistics.
  int bht_m [BHT_DEPTH];
  int bcnt_m;
  int mcnt_m;

  // Current stimulus, mirrored so the model never reads the DUT.
  logic [1:0]  s_pcs;
  logic [2:0]  s_f3;
  logic [2:0]  s_flags;
  logic        s_rv;
  logic [31:0] s_pce;
  logic        s_pe;
  logic [31:0] s_pcf;
  logic        s_clr;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % BHT_DEPTH);
  endfunction

  function automatic bit m_legal(input logic [2:0] f3);
    return !(f3 == 3'd2 || f3 == 3'd3);
  endfunction

  function automatic bit m_taken(input logic [2:0] f3, input logic [2:0] flags);
    bit eq, lt, ltu;
    eq  = flags[2];
    lt  = flags[1];
    ltu = flags[0];
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_is_br();
    return s_rv && s_pcs == 2'd1 && m_legal(s_f3);
  endfunction

  function automatic logic [1:0] m_pcsrc();
    if (!s_rv) return 2'd0;
    case (s_pcs)
      2'd1:    return m_taken(s_f3, s_flags) ? 2'd1 : 2'd0;
      2'd2:    return 2'd1;
      2'd3:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic bit m_mis();
    return m_is_br() && (m_taken(s_f3, s_flags) != s_pe);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return bht_m[m_idx(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
    bcnt_m = 0;
    mcnt_m = 0;
  endtask

  task automatic drive(input logic [1:0] pcs, input logic [2:0] f3, input logic [2:0] flags,
                       input logic rv, input logic [31:0] pce, input logic pe,
                       input logic [31:0] pcf, input logic clr);
    s_pcs = pcs; s_f3 = f3; s_flags = flags; s_rv = rv;
    s_pce = pce; s_pe = pe; s_pcf = pcf; s_clr = clr;
    bus.PCS = pcs; bus.Funct3 = f3; bus.ALUFlags = flags; bus.ResolveValid = rv;
    bus.PCE = pce; bus.PredTakenE = pe; bus.PCF = pcf; bus.StatClear = clr;
    #1;
  endtask

  // Advance one clock and apply the architectural effect of the current stimulus.
  task automatic tick();
    bit upd, tk, mis;
    int i;
    upd = m_is_br();
    tk  = m_taken(s_f3, s_flags);
    mis = m_mis();
    i   = m_idx(s_pce);
    @(posedge CLK);
    if (upd) begin
      if (tk && bht_m[i] < 3) bht_m[i]++;
      if (!tk && bht_m[i] > 0) bht_m[i]--;
    end
    if (s_clr) begin
      bcnt_m = 0;
      mcnt_m = 0;
    end else begin
      if (upd && bcnt_m < STAT_MAX) bcnt_m++;
      if (mis && mcnt_m < STAT_MAX) mcnt_m++;
    end
    #1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    model_reset();
    drive(2'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0);
    #10;
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (bus.PredTakenF !== 1'b0) begin
      n_fail++; $display("FAIL reset_pred got=%b want=0", bus.PredTakenF);
    end
    n_cmp++;
    if (bus.BranchCount !== 4'd0 || bus.MispredictCount !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_counts got=%0d/%0d want=0/0", bus.BranchCount, bus.MispredictCount);
    end
    drive(2'd2, 3'd0, 3'd0, 1'b1, 32'h10, 1'b0, 32'h100, 1'b0);
    n_cmp++;
    if (bus.PCSrc !== 2'b01 || bus.Mispredict !== 1'b0) begin
      n_fail++; $display("FAIL jal got=%b/%b want=01/0", bus.PCSrc, bus.Mispredict);
    end
    tick();
    drive(2'd3, 3'd0, 3'd0, 1'b1, 32'h14, 1'b0, 32'h100, 1'b0);
    n_cmp++;
    if (bus.PCSrc !== 2'b10 || bus.Mispredict !== 1'b0) begin
      n_fail++; $display("FAIL jalr got=%b/%b want=10/0", bus.PCSrc, bus.Mispredict);
    end
    tick();
  endtask

  logic [2:0] cond_f3  [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [1:0] cond_exp [6] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};

  task automatic test_conditions();
    for (int i = 0; i < 6; i++) begin
      drive(2'd1, cond_f3[i], 3'b010, 1'b1, 32'h200 + 32'(i * 4), 1'b0, 32'h300, 1'b0);
      n_cmp++;
      if (bus.PCSrc !== cond_exp[i] || bus.PCSrc !== m_pcsrc()) begin
        n_fail++; $display("FAIL cond_pcsrc f3=%0d got=%b want=%b", cond_f3[i], bus.PCSrc,
                           cond_exp[i]);
      end
      n_cmp++;
      if (bus.Mispredict !== cond_exp[i][0]) begin
        n_fail++; $display("FAIL cond_mis f3=%0d got=%b want=%b", cond_f3[i], bus.Mispredict,
                           cond_exp[i][0]);
      end
      tick();
    end
    drive(2'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h300, 1'b0);
    n_cmp++;
    if (bus.BranchCount !== 4'd6 || bus.MispredictCount !== 4'd3) begin
      n_fail++;
      $display("FAIL cond_counts got=%0d/%0d want=6/3", bus.BranchCount, bus.MispredictCount);
    end
  endtask

  logic exp_train [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic test_bht_train();
    for (int k = 0; k < 8; k++) begin
      logic [2:0] fl;
      fl = (k < 3) ? 3'b100 : 3'b000;
      drive(2'd1, 3'd0, fl, 1'b1, 32'h40, exp_train[k], 32'h40, 1'b0);
      n_cmp++;
      if (bus.PredTakenF !== exp_train[k] || bus.PredTakenF !== m_pred(32'h40)) begin
        n_fail++; $display("FAIL train_pred step=%0d got=%b want=%b", k, bus.PredTakenF,
                           exp_train[k]);
      end
      n_cmp++;
      if (bus.Mispredict !== m_mis()) begin
        n_fail++; $display("FAIL train_mis step=%0d got=%b want=%b", k, bus.Mispredict,
                           m_mis());
      end
      tick();
    end
    drive(2'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0);
    n_cmp++;
    if (bus.PredTakenF !== 1'b0 || bht_m[16] != 0) begin
      n_fail++; $display("FAIL train_floor got=%b want=0", bus.PredTakenF);
    end
  endtask

  task automatic test_illegal();
    int bc, mc;
    // 0x44 sits at weakly-not-taken: any stray increment flips its prediction.
    bc = bcnt_m;
    mc = mcnt_m;
    drive(2'd1, 3'd2, 3'b110, 1'b1, 32'h44, 1'b0, 32'h44, 1'b0);
    n_cmp++;
    if (bus.PCSrc !== 2'b00 || bus.Mispredict !== 1'b0) begin
      n_fail++; $display("FAIL illegal_out got=%b/%b want=00/0", bus.PCSrc, bus.Mispredict);
    end
    tick();
    drive(2'd1, 3'd0, 3'b100, 1'b0, 32'h44, 1'b0, 32'h44, 1'b0);
    n_cmp++;
    if (bus.PredTakenF !== 1'b0 || bus.BranchCount !== 4'(bc)) begin
      n_fail++; $display("FAIL illegal_noupd got=%b/%0d want=0/%0d", bus.PredTakenF,
                         bus.BranchCount, bc);
    end
    n_cmp++;
    if (bus.PCSrc !== 2'b00) begin
      n_fail++; $display("FAIL bubble_pcsrc got=%b want=00", bus.PCSrc);
    end
    tick();
    drive(2'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
    n_cmp++;
    if (bus.PredTakenF !== 1'b0 || bus.BranchCount !== 4'(bc) ||
        bus.MispredictCount !== 4'(mc)) begin
      n_fail++; $display("FAIL bubble_noupd got=%b/%0d/%0d want=0/%0d/%0d", bus.PredTakenF,
                         bus.BranchCount, bus.MispredictCount, bc, mc);
    end
  endtask

  task automatic test_stat_saturate();
    drive(2'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(2'd1, 3'd0, 3'b100, 1'b1, 32'h80 + 32'((i % 4) * 4), 1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(2'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (bus.BranchCount !== 4'd15 || bus.MispredictCount !== 4'd15) begin
      n_fail++;
      $display("FAIL stat_sat got=%0d/%0d want=15/15", bus.BranchCount, bus.MispredictCount);
    end
    drive(2'd1, 3'd0, 3'b100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    tick();
    drive(2'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (bus.BranchCount !== 4'd0 || bus.MispredictCount !== 4'd0) begin
      n_fail++;
      $display("FAIL stat_clear got=%0d/%0d want=0/0", bus.BranchCount, bus.MispredictCount);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pce, pcf;
      pce = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) * 4);
      pcf = $urandom_range(0, 1) ? (($urandom & 32'hFFFF_FF00) | (pce & 32'hFC))
                                 : ($urandom & 32'hFFFF_FFFC);
      drive(2'($urandom), 3'($urandom), 3'($urandom), $urandom_range(0, 4) != 0, pce,
            1'($urandom), pcf, $urandom_range(0, 15) == 0);
      n_cmp++;
      if (bus.PCSrc !== m_pcsrc() || bus.Mispredict !== m_mis() ||
          bus.PredTakenF !== m_pred(pcf)) begin
        n_fail++;
        $display("FAIL rand_comb n=%0d got=%b/%b/%b want=%b/%b/%b", n, bus.PCSrc,
                 bus.Mispredict, bus.PredTakenF, m_pcsrc(), m_mis(), m_pred(pcf));
      end
      n_cmp++;
      if (bus.BranchCount !== 4'(bcnt_m) || bus.MispredictCount !== 4'(mcnt_m)) begin
        n_fail++;
        $display("FAIL rand_counts n=%0d got=%0d/%0d want=%0d/%0d", n, bus.BranchCount,
                 bus.MispredictCount, bcnt_m, mcnt_m);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      drive(2'd1, 3'd0, 3'b100, 1'b1, 32'h40, 1'b0, 32'h40, 1'b0);
      tick();
    end
    drive(2'd2, 3'd0, 3'd0, 1'b1, 32'h40, 1'b0, 32'h40, 1'b0);
    n_cmp++;
    if (bus.PredTakenF !== 1'b1 || bus.BranchCount !== 4'(bcnt_m)) begin
      n_fail++; $display("FAIL pre_reset got=%b/%0d want=1/%0d", bus.PredTakenF,
                         bus.BranchCount, bcnt_m);
    end
    #2;
    RESETn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.PredTakenF !== 1'b0 || bus.BranchCount !== 4'd0 ||
        bus.MispredictCount !== 4'd0) begin
      n_fail++; $display("FAIL async_reset got=%b/%0d/%0d want=0/0/0", bus.PredTakenF,
                         bus.BranchCount, bus.MispredictCount);
    end
    n_cmp++;
    if (bus.PCSrc !== 2'b00 || bus.Mispredict !== 1'b0) begin
      n_fail++; $display("FAIL reset_pcsrc got=%b/%b want=00/0", bus.PCSrc, bus.Mispredict);
    end
    drive(2'd1, 3'd0, 3'b100, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0);
    @(posedge CLK);
    #1;
    n_cmp++;
    if (bus.PCSrc !== 2'b00 || bus.PredTakenF !== 1'b0 || bus.BranchCount !== 4'd0) begin
      n_fail++; $display("FAIL reset_hold got=%b/%b/%0d want=00/0/0", bus.PCSrc,
                         bus.PredTakenF, bus.BranchCount);
    end
    RESETn = 1'b1;
    drive(2'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0);
    tick();
    n_cmp++;
    if (bus.PredTakenF !== 1'b0 || bus.BranchCount !== 4'd0) begin
      n_fail++; $display("FAIL post_reset got=%b/%0d want=0/0", bus.PredTakenF,
                         bus.BranchCount);
    end
  endtask

  initial begin
    test_reset();
    test_conditions();
    test_bht_train();
    test_illegal();
    test_stat_saturate();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_unit_bht.md
Name: branch_unit_bht

Overview:
Successor to the single-bit conditional PC-select logic. It resolves all six RV32I branch conditions plus jal/jalr, and drives a 2-bit PC-source select. It adds a parametrised branch history table (BHT) of saturating counters:
- read at Fetch for a taken/not-taken prediction;
- updated at Execute when a conditional branch resolves.

It flags mispredictions to the hazard unit and keeps saturating branch/mispredict statistics for the memory-mapped performance registers.

Parameters:
PC_WIDTH, 32, width of PC inputs
BHT_DEPTH, 64, number of BHT entries; power of 2, >=2
CNT_WIDTH, 2, bits per saturating counter; >=1
STAT_WIDTH, 16, width of each statistics counter

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  asynchronous, active-low reset
PCS  in  2  00 non-control, 01 conditional branch, 10 jal, 11 jalr (Execute stage)
Funct3  in  3  branch condition: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
ALUFlags  in  3  {eq, lt, ltu} from ALU compare
ResolveValid  in  1  Execute instruction is real (not bubble, not stalled)
PCE  in  PC_WIDTH  PC of the resolving instruction
PredTakenE  in  1  prediction made for that instruction at Fetch (piped down)
PCF  in  PC_WIDTH  Fetch-stage PC for lookup
PredTakenF  out  1  prediction for PCF
PCSrc  out  2  00 PC+4, 01 PC+imm (taken branch/jal), 10 rs1+imm (jalr)
Mispredict  out  1  resolved direction differs from PredTakenE
StatClear  in  1  synchronous clear of statistics counters
BranchCount  out  STAT_WIDTH  legal conditional branches resolved
MispredictCount  out  STAT_WIDTH  mispredicted conditional branches

Behaviour:
- Clock and reset: one clock, CLK. RESETn is asynchronous, active-low.
- Reset:
  - Every BHT entry loads weakly-not-taken, value 2^(CNT_WIDTH-1)-1 (01 for 2-bit; 0 for CNT_WIDTH=1).
  - BranchCount and MispredictCount load 0.
  - PredTakenF therefore reads 0.
  - While RESETn is low, PCSrc=00 and Mispredict=0, and no table write occurs.
  - Reset asserted mid-operation discards any pending update immediately.
- Index: IDX = PC[log2(BHT_DEPTH)+1:2]. Bits [1:0] are ignored.
- Prediction:
  - PredTakenF = MSB of entry[IDX(PCF)]. Combinational from the registered table.
  - Zero-cycle lookup.
- Direction taken (combinational), valid when PCS=01:
  - beq = eq; bne = ~eq; blt = lt; bge = ~lt; bltu = ltu; bgeu = ~ltu.
  - Funct3 010/011 is illegal: taken=0.
- PCSrc (combinational):
  - 00 when ResolveValid=0.
  - PCS=00 -> 00.
  - PCS=01 -> 01 if taken, else 00.
  - PCS=10 -> 01.
  - PCS=11 -> 10.
- Mispredict (combinational):
  - 1 iff ResolveValid, PCS=01, legal Funct3 and taken != PredTakenE.
  - jal/jalr never assert Mispredict; they always redirect via PCSrc.
- Update, on the rising edge when ResolveValid and PCS=01 and Funct3 is legal:
  - entry[IDX(PCE)] increments if taken, decrements if not.
  - It saturates at 0 and at 2^CNT_WIDTH-1.
  - Illegal Funct3, bubbles and jal/jalr do not update.
- Read-during-write: if IDX(PCF)==IDX(PCE) in the update cycle, PredTakenF shows the pre-update value. The new value is visible from the next cycle.
- Statistics:
  - BranchCount +1 on each update event. MispredictCount +1 when Mispredict=1.
  - Both saturate at all-ones; no wrap.
  - StatClear has priority over a same-cycle increment, giving 0 next cycle.
  - Counters are registered, so an increment is visible one cycle after the event.
- Aliasing: PCs differing only above the index bits share an entry. This is intended; no tags.

Decomposition:
- Shared package/include riscv_ctrl_defs:
  - PCS encodings (PCS_NONE/BR/JAL/JALR);
  - Funct3 branch codes;
  - PCSrc encodings (PCSRC_PC4/PCIMM/RS1IMM);
  - ALUFlags bit positions (FLAG_EQ=2, FLAG_LT=1, FLAG_LTU=0).
- One sub-module, bht_sat_table: DEPTH x CNT_WIDTH counter array with async reset, one combinational read port, one saturating inc/dec write port.
- Resolution logic and statistics stay in branch_unit_bht.

Test Plan:
- Reset then PCF=0x100 -> PredTakenF=0, both counts 0. PCS=10, ResolveValid=1 -> PCSrc=01, Mispredict=0. PCS=11 -> PCSrc=10.
- All six Funct3 with ALUFlags=3'b010 (lt only), PCS=01, PredTakenE=0 -> PCSrc 00,01,01,00,00,01 for beq,bne,blt,bge,bltu,bgeu. Mispredict matches PCSrc[0]. BranchCount=6, MispredictCount=3.
- PCE=PCF=0x40: beq taken twice -> entry 01->10->11. PredTakenF=0 during the first update cycle, 1 from the next cycle. A third taken stays 11. Then four not-taken -> 00 and stays 00.
- Funct3=010 with PCS=01, ResolveValid=1 -> PCSrc=00, Mispredict=0, no table change, BranchCount unchanged. Same stimulus with ResolveValid=0 and beq taken -> no update.
- STAT_WIDTH=4: 20 mispredicted branches -> both counts hold 15. StatClear asserted together with a branch -> 0 next cycle.
- RESETn pulled low asynchronously mid-stream after training entry 0x40 to 11 -> PredTakenF=0 and counts=0 without waiting for a clock edge. PCSrc=00 while RESETn is low.
